// File: rtl/fill_pkg.sv
// Shared definitions for the fill engine: frame-buffer geometry, bus widths
// and the span-writer state encoding (also used by fill_controller).
package fill_pkg;

  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int COLOR_W = 24;
  localparam int ADDR_W  = 19;

  // Coordinate widths on the span request interface.
  localparam int X_W = 10;
  localparam int Y_W = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } span_state_t;

endpackage

// File: rtl/fill_pixel_counter.sv
// Column counter for one span: loaded with the first and last column,
// advances once per accepted write, flags the last column.
module fill_pixel_counter #(
  parameter int X_W = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [X_W-1:0] start_val,
  input  logic [X_W-1:0] end_val,
  input  logic           enable,
  output logic [X_W-1:0] x,
  output logic           tc
);

  logic [X_W-1:0] x_end;

  // Load the span bounds, then step x on each accepted write; hold at the end.
  always_ff @(posedge clk) begin
    if (rst) begin
      x     <= '0;
      x_end <= '0;
    end else if (load) begin
      x     <= start_val;
      x_end <= end_val;
    end else if (enable && !tc) begin
      x <= x + 1'b1;
    end
  end

  assign tc = (x == x_end);

endmodule

// File: rtl/fill_span_writer.sv
// Writes one horizontal span of a solid colour into the linear frame buffer,
// one pixel per accepted write, and reports completion with a one-cycle pulse.
module fill_span_writer #(
  parameter int H_RES   = fill_pkg::H_RES,
  parameter int V_RES   = fill_pkg::V_RES,
  parameter int COLOR_W = fill_pkg::COLOR_W,
  parameter int ADDR_W  = fill_pkg::ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fill_start,
  input  logic [fill_pkg::X_W-1:0] x_left,
  input  logic [fill_pkg::X_W-1:0] x_right,
  input  logic [fill_pkg::Y_W-1:0] y_row,
  input  logic [COLOR_W-1:0]      color,
  input  logic                    wr_ready,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [COLOR_W-1:0]      wr_data,
  output logic                    fill_done,
  output logic                    busy
);

  import fill_pkg::*;

  localparam int             YL_W  = Y_W + 1;
  localparam logic [X_W-1:0] X_MAX = X_W'(H_RES - 1);
  localparam logic [YL_W-1:0] Y_LIM = YL_W'(V_RES);

  // Row start address; the default 640-wide frame uses 512+128 shifts.
  function automatic logic [ADDR_W-1:0] row_base(input logic [Y_W-1:0] y);
    logic [ADDR_W-1:0] yw;
    yw = ADDR_W'(y);
    if (H_RES == 640) row_base = (yw << 9) + (yw << 7);
    else              row_base = yw * ADDR_W'(H_RES);
  endfunction

  span_state_t        state, state_d;
  logic               start_q, armed;
  logic [X_W-1:0]     xl_q, xr_q;
  logic [Y_W-1:0]     y_q;
  logic [COLOR_W-1:0] color_q;
  logic [ADDR_W-1:0]  base_q;
  logic               trigger, cnt_load, span_ok;
  logic [X_W-1:0]     x_start, x_hi, x_end, x;
  logic               tc;

  // The reset value of start_q is not a real low sample, so a request must
  // be seen low at least once after reset before a rising edge can count.
  assign trigger = fill_start && !start_q && armed;

  // Request edge history plus the span parameters captured when a span starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= 1'b0;
      armed   <= 1'b0;
      xl_q    <= '0;
      xr_q    <= '0;
      y_q     <= '0;
      color_q <= '0;
      base_q  <= '0;
    end else begin
      start_q <= fill_start;
      if (!fill_start) armed <= 1'b1;
      if (state == IDLE && trigger) begin
        xl_q    <= x_left;
        xr_q    <= x_right;
        y_q     <= y_row;
        color_q <= color;
      end
      if (state == LOAD) base_q <= row_base(y_q);
    end
  end

  // Order the bounds, clamp the right edge and reject off-screen spans.
  always_comb begin
    x_start = xl_q;
    x_hi    = xr_q;
    if (xl_q > xr_q) begin
      x_start = xr_q;
      x_hi    = xl_q;
    end
    x_end   = (x_hi > X_MAX) ? X_MAX : x_hi;
    span_ok = (x_start <= X_MAX) && ({1'b0, y_q} < Y_LIM);
  end

  fill_pixel_counter #(
    .X_W (X_W)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .start_val (x_start),
    .end_val   (x_end),
    .enable    (wr_en && wr_ready),
    .x         (x),
    .tc        (tc)
  );

  assign wr_addr = base_q + ADDR_W'(x);
  assign wr_data = color_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state and per-state outputs.
  always_comb begin
    state_d   = state;
    wr_en     = 1'b0;
    fill_done = 1'b0;
    busy      = 1'b1;
    cnt_load  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (trigger) state_d = LOAD;
      end
      LOAD: begin
        cnt_load = 1'b1;
        state_d  = span_ok ? WRITE : DONE;
      end
      WRITE: begin
        wr_en = 1'b1;
        if (wr_ready && tc) state_d = DONE;
      end
      DONE: begin
        fill_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fill_span_writer.sv
// Randomised span bench for fill_span_writer against a list-of-addresses model.
module tb_fill_span_writer;

  localparam int H = 640;
  localparam int V = 480;

  logic        clk = 1'b0;
  logic        rst;
  logic        fill_start;
  logic [9:0]  x_left, x_right;
  logic [8:0]  y_row;
  logic [23:0] color;
  logic        wr_ready;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic [23:0] wr_data;
  logic        fill_done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fill_span_writer dut (
    .clk        (clk),
    .rst        (rst),
    .fill_start (fill_start),
    .x_left     (x_left),
    .x_right    (x_right),
    .y_row      (y_row),
    .color      (color),
    .wr_ready   (wr_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .fill_done  (fill_done),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // rdy: 100 = always ready, -1 = alternate 0,1 from the first write, else percent.
  task automatic run_span(input int xl, input int xr, input int y, input int col,
                          input int rdy, input bit drop);
    int          lo, hi, xe, n, written;
    int          exp_q[$];
    bit          done_seen;
    bit          held;
    logic [31:0] exp_data;
    lo = (xl < xr) ? xl : xr;
    hi = (xl < xr) ? xr : xl;
    xe = (hi > H - 1) ? H - 1 : hi;
    if (lo <= H - 1 && y < V)
      for (int px = lo; px <= xe; px++) exp_q.push_back(y * H + px);
    n         = exp_q.size();
    written   = 0;
    done_seen = 0;
    held      = 0;
    exp_data  = col & 32'h00FF_FFFF;
    @(negedge clk);
    x_left     = 10'(xl);
    x_right    = 10'(xr);
    y_row      = 9'(y);
    color      = 24'(col);
    fill_start = 1'b1;
    for (int c = 0; c < 40 * n + 40 && !done_seen; c++) begin
      @(negedge clk);
      if (rdy == 100)     wr_ready = 1'b1;
      else if (rdy < 0)   wr_ready = (c % 2 == 0);
      else                wr_ready = ($urandom_range(0, 99) < rdy);
      if (c == 0) chk("load_wr_en", wr_en, 0);
      if (c == 1) begin
        x_left  = 10'($urandom);
        x_right = 10'($urandom);
        y_row   = 9'($urandom);
        color   = 24'($urandom);
      end
      if (drop && c == 2) fill_start = 1'b0;
      if (held) chk("hold_wr_en", wr_en, 1);
      held = 0;
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          chk("extra_write", wr_addr, 32'hFFFF_FFFF);
        end else begin
          chk("wr_addr", wr_addr, exp_q[0]);
          chk("wr_data", wr_data, exp_data);
          if (rdy == 100) chk("lat_write", c, 1 + written);
          if (wr_ready) begin
            void'(exp_q.pop_front());
            written++;
          end else begin
            held = 1;
          end
        end
      end
      if (fill_done) begin
        chk("done_left", exp_q.size(), 0);
        chk("done_wr_en", wr_en, 0);
        if (rdy == 100) chk("lat_done", c, 1 + n);
        done_seen = 1;
      end else begin
        chk("busy", busy, 1);
      end
    end
    chk("done_seen", done_seen, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_done", fill_done, 0);
      chk("post_busy", busy, 0);
      chk("post_wr_en", wr_en, 0);
    end
    fill_start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    rst        = 1'b1;
    fill_start = 1'b0;
    wr_ready   = 1'b0;
    x_left     = '0;
    x_right    = '0;
    y_row      = '0;
    color      = '0;
    repeat (2) @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", fill_done, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    rst = 1'b0;
    @(negedge clk);

    run_span(10, 13, 2, 32'h123456, 100, 0);
    run_span(20, 18, 0, 32'hABCDEF, 100, 0);
    run_span(5, 5, 479, 32'h00FF00, -1, 0);
    run_span(630, 700, 1, 32'h0000FF, 100, 1);
    run_span(3, 9, 480, 32'hFF0000, 100, 0);
    run_span(700, 800, 4, 32'h777777, 100, 0);

    // Reset in the middle of a 10-pixel span, request level still high.
    @(negedge clk);
    x_left = 10'd100; x_right = 10'd109; y_row = 9'd3; color = 24'h5A5A5A;
    wr_ready = 1'b1; fill_start = 1'b1;
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      if (wr_en && wr_addr == 19'(3 * H + 102)) hit = 1;
    end
    chk("reach_3rd", hit, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", fill_done, 0);
    chk("midrst_addr", wr_addr, 0);
    chk("midrst_data", wr_data, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_restart_busy", busy, 0);
      chk("no_restart_done", fill_done, 0);
      chk("no_restart_wr_en", wr_en, 0);
    end
    fill_start = 1'b0;
    @(negedge clk);
    run_span(100, 109, 3, 32'h5A5A5A, 100, 0);

    for (int i = 0; i < 14; i++) begin
      int xl, xr, y, rd;
      if ($urandom_range(0, 3) == 0) begin
        xl = $urandom_range(0, 1023);
        xr = $urandom_range(0, 1023);
      end else begin
        xl = $urandom_range(0, 639);
        xr = xl + $urandom_range(0, 12) - 6;
        if (xr < 0) xr = 0;
      end
      y  = $urandom_range(0, 511);
      rd = ($urandom_range(0, 1) == 1) ? 100 : $urandom_range(50, 90);
      run_span(xl, xr, y, $urandom, rd, $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
